// File: rtl/fifo_pkg.sv
// Shared parameters and state encoding for the FIFO read-side packer.
package fifo_pkg;

  localparam int DATA_WIDTH = 4;
  localparam int PACK_RATIO = 4;
  localparam int LANE_W     = $clog2(PACK_RATIO + 1);

  typedef enum logic [1:0] {
    S_ACCUM,
    S_FULL,
    S_FLUSH
  } pack_state_t;

endpackage

// File: rtl/fifo_rd_packer_pkt_out_reg.sv
// Output holding register for the packer: one wide word plus its lane count,
// presented on a valid/ready port and held stable until accepted.
module pkt_out_reg
  import fifo_pkg::*;
#(
  parameter int WORD_WIDTH  = DATA_WIDTH * PACK_RATIO,
  parameter int LANES_WIDTH = LANE_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_load,
  input  logic [WORD_WIDTH-1:0]  i_data,
  input  logic [LANES_WIDTH-1:0] i_lanes,
  input  logic                   i_ready,
  output logic [WORD_WIDTH-1:0]  o_data,
  output logic [LANES_WIDTH-1:0] o_lanes,
  output logic                   o_valid,
  output logic                   o_free
);

  // The register can accept a new word when it is empty or being drained this cycle.
  assign o_free = !o_valid || i_ready;

  // Load takes priority over release so a completing word overlaps the handshake with no idle cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data  <= '0;
      o_lanes <= '0;
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_data  <= i_data;
      o_lanes <= i_lanes;
      o_valid <= 1'b1;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains narrow FIFO entries and packs PACK_RATIO of them (lane 0 in the LSBs)
// into one wide word; a flush emits a zero-padded partial word.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int PACK_RATIO = fifo_pkg::PACK_RATIO
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_empty,
  input  logic [DATA_WIDTH-1:0]              i_fifo_data,
  output logic                               o_rd_en,
  input  logic                               i_flush,
  output logic [DATA_WIDTH*PACK_RATIO-1:0]   o_pkt_data,
  output logic [$clog2(PACK_RATIO+1)-1:0]    o_pkt_lanes,
  output logic                               o_pkt_valid,
  input  logic                               i_pkt_ready
);

  localparam int WORD_W  = DATA_WIDTH * PACK_RATIO;
  localparam int LANES_W = $clog2(PACK_RATIO + 1);
  localparam logic [LANES_W-1:0] FULL_LANES = LANES_W'(PACK_RATIO);

  pack_state_t        r_state, w_nextState;
  logic [LANES_W-1:0] r_laneCnt, w_laneNext, w_laneFilled, w_loadLanes;
  logic               r_rdPend;
  logic [WORD_W-1:0]  r_acc, w_accNext, w_accFilled, w_loadData;
  logic               w_load, w_outFree, w_lastCapture;

  // Lanes held plus the one in flight; reads stop once that reaches a full word.
  assign w_laneFilled  = r_laneCnt + LANES_W'(r_rdPend);
  assign w_lastCapture = r_rdPend && (w_laneFilled == FULL_LANES);
  assign o_rd_en       = !i_empty && (r_state == S_ACCUM) && (w_laneFilled < FULL_LANES);

  // Accumulator as it looks after this cycle's capture (if any) lands in lane r_laneCnt.
  always_comb begin
    w_accFilled = r_acc;
    for (int l = 0; l < PACK_RATIO; l++) begin
      if (r_rdPend && (r_laneCnt == LANES_W'(l))) begin
        w_accFilled[l*DATA_WIDTH +: DATA_WIDTH] = i_fifo_data;
      end
    end
  end

  // Packer FSM: decides when a word (full or partial) moves to the output register.
  always_comb begin
    w_nextState = r_state;
    w_accNext   = r_acc;
    w_laneNext  = r_laneCnt;
    w_load      = 1'b0;
    w_loadData  = r_acc;
    w_loadLanes = r_laneCnt;
    case (r_state)
      S_ACCUM: begin
        w_accNext  = w_accFilled;
        w_laneNext = w_laneFilled;
        if (w_lastCapture) begin
          if (w_outFree) begin
            w_load      = 1'b1;
            w_loadData  = w_accFilled;
            w_loadLanes = FULL_LANES;
            w_accNext   = '0;
            w_laneNext  = '0;
          end else begin
            w_nextState = S_FULL;
          end
        end else if (i_flush && (w_laneFilled != '0)) begin
          w_nextState = S_FLUSH;
        end
      end
      S_FULL: begin
        if (w_outFree) begin
          w_load      = 1'b1;
          w_loadData  = r_acc;
          w_loadLanes = FULL_LANES;
          w_accNext   = '0;
          w_laneNext  = '0;
          w_nextState = S_ACCUM;
        end
      end
      S_FLUSH: begin
        w_accNext  = w_accFilled;
        w_laneNext = w_laneFilled;
        if (!r_rdPend && w_outFree) begin
          w_load      = 1'b1;
          w_loadData  = r_acc;
          w_loadLanes = r_laneCnt;
          w_accNext   = '0;
          w_laneNext  = '0;
          w_nextState = S_ACCUM;
        end
      end
      default: begin
        w_nextState = S_ACCUM;
      end
    endcase
  end

  // State, accumulator and in-flight read tracking; reset drops any partial word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_ACCUM;
      r_laneCnt <= '0;
      r_rdPend  <= 1'b0;
      r_acc     <= '0;
    end else begin
      r_state   <= w_nextState;
      r_laneCnt <= w_laneNext;
      r_rdPend  <= o_rd_en;
      r_acc     <= w_accNext;
    end
  end

  pkt_out_reg #(
    .WORD_WIDTH  (WORD_W),
    .LANES_WIDTH (LANES_W)
  ) u_out (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_data  (w_loadData),
    .i_lanes (w_loadLanes),
    .i_ready (i_pkt_ready),
    .o_data  (o_pkt_data),
    .o_lanes (o_pkt_lanes),
    .o_valid (o_pkt_valid),
    .o_free  (w_outFree)
  );

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Downstream consumer of the synchronous `fifo`. It drains `DATA_WIDTH`-bit entries from the FIFO read port and packs `PACK_RATIO` consecutive entries into one wide word, which it presents on a valid/ready output port. A `flush` request emits a partially filled word, zero-padded. It is the next stage after the FIFO in the datapath and is verified in the same bench environment.

## Interface
- `DATA_WIDTH`, 4: FIFO entry width; must match the FIFO instance.
- `PACK_RATIO`, 4: FIFO entries per output word; must be at least 2.
- `clk` in, 1: single clock; all logic is posedge.
- `rst` in, 1: asynchronous, active-high reset, shared with the FIFO.
- `empty` in, 1: FIFO empty flag.
- `fifo_data` in, `DATA_WIDTH`: FIFO `data_out`.
- `rd_en` out, 1: FIFO read strobe.
- `flush` in, 1: single-cycle pulse requesting emission of a partial word.
- `pkt_data` out, `DATA_WIDTH*PACK_RATIO`: packed word; lane 0 is in the LSBs.
- `pkt_lanes` out, `$clog2(PACK_RATIO+1)`: number of valid lanes in `pkt_data`.
- `pkt_valid` out, 1: `pkt_data` and `pkt_lanes` are valid.
- `pkt_ready` in, 1: consumer accepts the word.

## Operation
- **FIFO read contract.** `rd_en` is sampled at posedge k. `fifo_data` holds that entry after edge k and is captured by the packer at edge k+1. Reads may be issued back-to-back.
- **Read strobe.** `rd_en = !empty && state==S_ACCUM && (lane_cnt + rd_pend) < PACK_RATIO`.
  - `rd_en` is never asserted while `empty` is high.
  - `rd_pend` is a 1-bit in-flight flag.
- **Lane fill.** Each captured entry is written to lane `lane_cnt`, then `lane_cnt` increments. Fill is in arrival order, LSB lane first.
- **Output holding register.** An occupied register releases on `pkt_valid && pkt_ready`.
  - The capture that fills the last lane loads the register directly when it is empty or draining that cycle. The accumulator then clears.
  - Otherwise the state moves to S_FULL.
- **States.**
  - S_ACCUM:
    - A full accumulator with the output busy goes to S_FULL.
    - `flush` with `lane_cnt + rd_pend > 0` goes to S_FLUSH.
    - `flush` with nothing held or pending is ignored.
  - S_FULL: no reads are issued. When the output frees, the accumulator transfers to the output and the state returns to S_ACCUM.
  - S_FLUSH: no new reads are issued. Once `rd_pend == 0` and the output is free, the block loads `pkt_data` with the filled lanes and upper lanes zero, sets `pkt_lanes = lane_cnt`, clears the accumulator, and returns to S_ACCUM.
- `flush` arriving in S_FULL or S_FLUSH is ignored.
- **Output stability.** `pkt_data` and `pkt_lanes` are stable while `pkt_valid && !pkt_ready`.
- `pkt_lanes` equals `PACK_RATIO` for every non-flush word.

## Timing
- **Reset values.** `rd_en=0`, `pkt_valid=0`, `pkt_data=0`, `pkt_lanes=0`. Internally `lane_cnt=0`, `rd_pend=0`, and the state is S_ACCUM.
- **Reset mid-operation.** An in-flight entry is discarded and any partial word is lost. This is acceptable because the FIFO resets on the same `rst`.
- **Latency.** With continuous data and the output free, the first `rd_en` edge is 0 and `pkt_valid` rises after edge `PACK_RATIO`.
- **Throughput.** One bubble per word, because no read is issued while the last lane is in flight. This gives `PACK_RATIO` entries per `PACK_RATIO+1` cycles.
- **Full word with backpressure.** While `pkt_ready` is low and the accumulator is full, reads halt. The FIFO then fills, and its flags are its own concern.
- **Simultaneous release and completion.** When `pkt_ready` completes a handshake on the same edge the last lane is captured, the new word loads with no idle cycle (`pkt_valid` stays high).
- **Flush latency.** A `flush` pulse at edge k with no pending read emits at edge k+1 if the output is free.

## Structure
- **Package `fifo_pkg`:**
  - `DATA_WIDTH` and `PACK_RATIO` defaults.
  - `LANE_W = $clog2(PACK_RATIO+1)`.
  - `typedef enum logic [1:0] {S_ACCUM, S_FULL, S_FLUSH} pack_state_t`.
- **Sub-module `pkt_out_reg`:** the output holding register with load, release, and valid/ready logic, keeping the packer FSM separate.

## Test plan
- **Basic pack.** FIFO preloaded with 1, 2, 3, 4; `pkt_ready=1` → `pkt_data=16'h4321`, `pkt_lanes=4`; `rd_en` asserts exactly 4 times.
- **Backpressure.** 8 entries 1..8 with `pkt_ready` held low → the first word `16'h4321` is held stable, and `rd_en` stays low after 4 more captures. After `pkt_ready` rises, words `16'h4321` then `16'h8765` are delivered in order with no loss.
- **Partial flush.** Entries 5, 6, 7, then `flush` → `pkt_data=16'h0765`, `pkt_lanes=3`.
- **Flush with a read in flight.** `flush` on the cycle after the single read of entry 9 → `pkt_data=16'h0009`, `pkt_lanes=1`. A `flush` with nothing held or pending produces no output.
- **Empty FIFO.** `rd_en` is never asserted across 20 cycles, and `pkt_valid` stays 0.
- **Reset mid-operation.** `rst` pulsed after 2 captures → all outputs return to 0. Refilling 1..4 then yields `16'h4321`.
